icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameter MAX_RETRY, default 3, meaning: number of wb_rty_i restarts tolerated per line before the fill aborts with an error.
REQ-002 Parameter LINE_WORDS, default 8, meaning: 32-bit words per cache line; it is fixed at 8 and not overridden.
REQ-003 clk  input  1  meaning: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  meaning: reset, asynchronous, active-low.
REQ-005 miss_req  input  1  meaning: line-fill request from the icache, sampled only in IDLE.
REQ-006 miss_addr  input  32  meaning: miss address; bits [4:0] are ignored.
REQ-007 line_data  output  256  meaning: assembled line; word k is at bits [32k+31:32k].
REQ-008 line_addr  output  32  meaning: line-aligned address of line_data, with bits [4:0] = 0.
REQ-009 line_we  output  1  meaning: one-cycle write strobe to the icache (its we/wr_data port).
REQ-010 busy  output  1  meaning: high in every state except IDLE.
REQ-011 fill_err  output  1  meaning: one-cycle pulse on an aborted fill.
REQ-012 Wishbone master ports: wb_ack_i, wb_err_i, wb_rty_i (in, 1 bit each); wb_dat_i (in, 32); wb_cyc_o, wb_stb_o, wb_we_o (out, 1 bit each); wb_adr_o (out, 32); wb_bte_o, wb_cti_o (out, 3 bits each); wb_sel_o (out, 4); wb_dat_o (out, 32).

Function
REQ-013 States: IDLE, BURST, RETRY_WAIT, DONE.
REQ-014 IDLE with miss_req=1: latch {miss_addr[31:5],5'b0} into line_addr, clear the beat and retry counters, and go to BURST on the next edge.
REQ-015 BURST: wb_cyc_o=wb_stb_o=1; wb_adr_o = {line_addr[31:5], beat[2:0], 2'b00}.
REQ-016 BURST bus constants: wb_we_o=0, wb_sel_o=4'hF, wb_dat_o=0, wb_bte_o=3'b000.
REQ-017 BURST cycle type: wb_cti_o=3'b010 for beats 0-6 and 3'b111 for beat 7.
REQ-018 In BURST, wb_ack_i=1 stores wb_dat_i into word[beat] and increments beat; with no ack, the address and data slots hold (wait states are unbounded).
REQ-019 An ack on beat 7 moves to DONE; wb_cyc_o and wb_stb_o drop on that same edge.
REQ-020 DONE lasts exactly one cycle: line_we=1 with stable line_data and line_addr, then return to IDLE.
REQ-021 Burst latency: line_we asserts 1 cycle after the 8th ack; with zero wait states, the miss_req sample is followed 9 cycles later by line_we.
REQ-022 wb_rty_i in BURST with retry count < MAX_RETRY: go to RETRY_WAIT (cyc/stb low for exactly 1 cycle), increment retry count, reset beat to 0, then re-enter BURST.
REQ-023 The retried burst restarts the whole line; slots from the previous attempt are overwritten before use.
REQ-024 wb_rty_i with retry count = MAX_RETRY, or wb_err_i at any beat: pulse fill_err for one cycle, drop cyc/stb, return to IDLE, and do not assert line_we.
REQ-025 Simultaneous ack/err/rty in one cycle: priority is err, then rty, then ack; the ack is discarded.
REQ-026 miss_req while busy=1 is ignored (no queueing); the icache re-requests after line_we or fill_err.
REQ-027 A request arriving in the DONE cycle is not accepted; it is accepted from IDLE on the following cycle.
REQ-028 line_data and line_addr hold their last values in IDLE until the next accepted request.
REQ-029 All outputs are registered; no combinational path exists from Wishbone inputs to Wishbone outputs.

Reset
REQ-030 rst_n=0 asynchronously forces: IDLE, wb_cyc_o=wb_stb_o=0, line_we=0, fill_err=0, busy=0.
REQ-031 rst_n=0 also zeroes line_data, line_addr, wb_adr_o, wb_cti_o and both counters; wb_sel_o reads 4'hF.
REQ-032 Reset mid-burst drops cyc/stb immediately with no line_we, and a clean IDLE follows rst_n release.

Verification
REQ-033 Zero-wait fill: miss_addr=0x0000_1234, slave returns 0x1000_0000+k on beat k.
- Required addresses: 0x1220,0x1224,...,0x123C.
- Required cti: 010 x7, then 111.
- Required result: line_we once, line_addr=0x1220, line_data word k = 0x1000_0000+k.
REQ-034 Wait states: 2 idle cycles before each ack.
- Required: address holds during waits, line_data as in REQ-033, line_we 1 cycle after the 8th ack.
REQ-035 Retry: rty on beat 3, then a clean burst.
- Required: exactly 1 cycle of cyc=0, restart at 0x..20, a single line_we, correct data.
REQ-036 Retry exhaustion: rty on every first beat with MAX_RETRY=3.
- Required: 4 bursts, then a fill_err pulse, no line_we, return to IDLE.
REQ-037 Error precedence: ack and err together on beat 5.
- Required: fill_err pulse, no line_we, busy low the following cycle; a second miss_req during the burst had no effect.
REQ-038 Reset mid-operation: rst_n low at beat 4.
- Required: cyc/stb low asynchronously, outputs at REQ-030/031 values.
- Then a new miss completes normally.

Source files
------------

// File: rtl/icache_refill_if.sv
// Wishbone B3 classic/burst signal bundle between the refill engine and the bus.
interface icache_refill_if;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [2:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;

  modport master (
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_bte_o, wb_cti_o, wb_sel_o, wb_dat_o
  );

  modport slave (
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_bte_o, wb_cti_o, wb_sel_o, wb_dat_o
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one 8-beat incrementing Wishbone read
// burst per miss, bounded restarts on retry, abort on error.
module icache_refill #(
  parameter int MAX_RETRY  = 3,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req,
  input  logic [31:0]              miss_addr,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic [31:0]              line_addr,
  output logic                     line_we,
  output logic                     busy,
  output logic                     fill_err,
  icache_refill_if.master          wb
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, RETRY_WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [31:0]   base_nxt;
  logic          store;
  logic          err_nxt;

  // Read-only burst: data/select/wrap fields never change.
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = 32'h0;
  assign wb.wb_bte_o = 3'b000;

  // Next-state and counter decode; bus response priority is err > rty > ack.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    retry_nxt = retry;
    base_nxt  = line_addr;
    store     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (miss_req) begin
        state_nxt = BURST;
        base_nxt  = {miss_addr[31:5], 5'b0};
        beat_nxt  = '0;
        retry_nxt = '0;
      end
      BURST: begin
        if (wb.wb_err_i) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (wb.wb_rty_i) begin
          if (retry == RW'(MAX_RETRY)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = RETRY_WAIT;
            retry_nxt = retry + RW'(1);
            beat_nxt  = '0;
          end
        end else if (wb.wb_ack_i) begin
          store    = 1'b1;
          beat_nxt = beat + BW'(1);
          if (beat == LAST_BEAT) state_nxt = DONE;
        end
      end
      RETRY_WAIT: state_nxt = BURST;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State, counters, latched line address and captured words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      retry     <= '0;
      line_addr <= '0;
      line_data <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      retry     <= retry_nxt;
      line_addr <= base_nxt;
      if (store) line_data[32*beat +: 32] <= wb.wb_dat_i;
    end
  end

  // Registered outputs decoded from the next state, so nothing on the bus
  // side is combinationally reachable from the Wishbone inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_cti_o <= 3'b000;
      line_we     <= 1'b0;
      busy        <= 1'b0;
      fill_err    <= 1'b0;
    end else begin
      wb.wb_cyc_o <= (state_nxt == BURST);
      wb.wb_stb_o <= (state_nxt == BURST);
      wb.wb_adr_o <= {base_nxt[31:5], beat_nxt, 2'b00};
      if (state_nxt == BURST) wb.wb_cti_o <= (beat_nxt == LAST_BEAT) ? 3'b111 : 3'b010;
      else                    wb.wb_cti_o <= 3'b000;
      line_we     <= (state_nxt == DONE);
      busy        <= (state_nxt != IDLE);
      fill_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed scenarios followed by randomized fills,
// checked against a transaction-level model of the Wishbone slave and line.
module tb_icache_refill;
  localparam int MAX_RETRY = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic [255:0] line_data;
  logic [31:0]  line_addr;
  logic         line_we, busy, fill_err;

  int checks = 0;
  int errors = 0;

  // Per-fill slave plan: retry beat per attempt (-1 = none), error point,
  // whether ack accompanies err/rty, and side-request options.
  int rty_plan[0:7];
  int err_att, err_beat;
  bit both_resp, mid_miss, done_miss, seq_data;

  icache_refill_if bus();

  icache_refill #(.MAX_RETRY(MAX_RETRY), .LINE_WORDS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .line_data (line_data),
    .line_addr (line_addr),
    .line_we   (line_we),
    .busy      (busy),
    .fill_err  (fill_err),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) rty_plan[i] = -1;
    err_att = -1; err_beat = -1;
    both_resp = 0; mid_miss = 0; done_miss = 0; seq_data = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cyc"},  {bus.wb_cyc_o, bus.wb_stb_o}, 2'b00);
    chk({tag, "_flags"}, {line_we, fill_err, busy}, 3'b000);
    chk({tag, "_line_data"}, line_data, '0);
    chk({tag, "_line_addr"}, line_addr, '0);
    chk({tag, "_adr_cti_sel"}, {bus.wb_adr_o, bus.wb_cti_o, bus.wb_sel_o}, {32'h0, 3'b000, 4'hF});
  endtask

  // Aborted fill: error pulse with IDLE in the same cycle, gone the next.
  task automatic expect_abort(input logic [31:0] base);
    chk("abort_pulse", {fill_err, line_we, busy, bus.wb_cyc_o, bus.wb_stb_o}, 5'b10000);
    @(posedge clk); #1;
    chk("abort_after", {fill_err, line_we, busy, bus.wb_cyc_o}, 4'b0000);
    chk("abort_line_addr", line_addr, base);
  endtask

  // Issue one miss and play the slave until line_we or fill_err.
  // outcome: 1 = line written, 2 = aborted, 0 = no conclusion.
  task automatic run_fill(input logic [31:0] addr, input int wmin, input int wmax,
                          output int outcome, output int edges, output int attempts);
    logic [31:0]  base;
    logic [255:0] exp_line;
    logic [31:0]  d;
    int beat, att, waits, n, resp;
    bit fin;
    base = {addr[31:5], 5'b0};
    exp_line = '0;
    beat = 0; att = 0; n = 0; fin = 0; outcome = 0;
    miss_addr = addr; miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0; edges = 1;
    chk("busy_on_accept", busy, 1'b1);
    waits = $urandom_range(wmax, wmin);
    while (!fin && n < 400) begin
      n++;
      chk("cyc_stb", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b11);
      chk("adr", bus.wb_adr_o, base + 32'(beat * 4));
      chk("cti", bus.wb_cti_o, (beat == 7) ? 3'b111 : 3'b010);
      chk("bus_const", {bus.wb_we_o, bus.wb_sel_o, bus.wb_bte_o, bus.wb_dat_o}, {1'b0, 4'hF, 3'b000, 32'h0});
      chk("burst_flags", {line_we, fill_err, busy}, 3'b001);
      resp = 0;
      if (waits > 0) waits--;
      else if (att == err_att && beat == err_beat) resp = 3;
      else if (rty_plan[att] == beat) resp = 2;
      else resp = 1;
      d = seq_data ? 32'h1000_0000 + 32'(beat) : $urandom;
      bus.wb_dat_i = d;
      bus.wb_ack_i = (resp == 1) || (resp > 1 && both_resp);
      bus.wb_rty_i = (resp == 2) || (resp == 3 && both_resp);
      bus.wb_err_i = (resp == 3);
      if (mid_miss && n == 2) begin miss_req = 1'b1; miss_addr = ~addr; end
      @(posedge clk); #1;
      edges++;
      bus.wb_ack_i = 0; bus.wb_rty_i = 0; bus.wb_err_i = 0; miss_req = 0;
      case (resp)
        1: begin
          exp_line[beat*32 +: 32] = d;
          beat++;
          if (beat == 8) begin
            chk("done_flags", {line_we, fill_err, busy, bus.wb_cyc_o, bus.wb_stb_o}, 5'b10100);
            chk("line_addr", line_addr, base);
            chk("line_data", line_data, exp_line);
            outcome = 1; fin = 1;
            if (done_miss) begin miss_req = 1'b1; miss_addr = addr + 32'h100; end
            @(posedge clk); #1;
            miss_req = 1'b0;
            chk("after_done", {line_we, busy, bus.wb_cyc_o}, 3'b000);
            chk("hold_addr", line_addr, base);
            chk("hold_data", line_data, exp_line);
          end else waits = $urandom_range(wmax, wmin);
        end
        2: if (att < MAX_RETRY) begin
          chk("retry_gap", {bus.wb_cyc_o, bus.wb_stb_o, busy, fill_err, line_we}, 5'b00100);
          att++; beat = 0;
          @(posedge clk); #1;
          edges++;
          waits = $urandom_range(wmax, wmin);
        end else begin
          expect_abort(base);
          outcome = 2; fin = 1;
        end
        3: begin
          expect_abort(base);
          outcome = 2; fin = 1;
        end
        default: ;
      endcase
    end
    attempts = att + 1;
    if (!fin) chk("fill_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int outcome, edges, attempts;
    logic [31:0] ra;
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_rty_i = 0; bus.wb_dat_i = '0;
    clear_plan();

    // Reset state
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, bus.wb_cyc_o, line_we}, 3'b000);

    // Zero-wait fill with known data and latency
    clear_plan(); seq_data = 1;
    run_fill(32'h0000_1234, 0, 0, outcome, edges, attempts);
    chk("zw_outcome", outcome, 1);
    chk("zw_latency", edges, 9);
    chk("zw_word7", line_data[255:224], 32'h1000_0007);

    // Two wait states before every ack
    clear_plan(); seq_data = 1;
    run_fill(32'h0000_1234, 2, 2, outcome, edges, attempts);
    chk("ws_outcome", outcome, 1);
    chk("ws_edges", edges, 1 + 8 * 3);

    // Retry on beat 3, then a clean burst with fresh data
    clear_plan(); rty_plan[0] = 3;
    run_fill(32'hABCD_0040, 0, 1, outcome, edges, attempts);
    chk("rty_outcome", outcome, 1);
    chk("rty_attempts", attempts, 2);

    // Retry on the first beat of every attempt exhausts the budget
    clear_plan(); for (int i = 0; i < 4; i++) rty_plan[i] = 0;
    run_fill(32'h0000_2000, 0, 0, outcome, edges, attempts);
    chk("exh_outcome", outcome, 2);
    chk("exh_attempts", attempts, MAX_RETRY + 1);

    // Error together with ack on beat 5; second request mid-burst ignored
    clear_plan(); err_att = 0; err_beat = 5; both_resp = 1; mid_miss = 1;
    run_fill(32'h0000_3000, 0, 0, outcome, edges, attempts);
    chk("err_outcome", outcome, 2);

    // Request during the DONE cycle is dropped, next one from IDLE works
    clear_plan(); done_miss = 1;
    run_fill(32'h0000_4000, 0, 1, outcome, edges, attempts);
    chk("dm_outcome", outcome, 1);
    clear_plan();
    run_fill(32'h0000_4100, 0, 0, outcome, edges, attempts);
    chk("dm_next_outcome", outcome, 1);

    // Reset at beat 4
    miss_addr = 32'h0000_5678; miss_req = 1'b1;
    @(posedge clk); #1 miss_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.wb_ack_i = 1; bus.wb_dat_i = 32'(k);
      @(posedge clk); #1;
      bus.wb_ack_i = 0;
    end
    chk("rst_pre_adr", {bus.wb_cyc_o, bus.wb_adr_o}, {1'b1, 32'h0000_5670});
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk); #1;
    chk_reset_vals("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", {busy, bus.wb_cyc_o, line_we, fill_err}, 4'b0000);
    clear_plan();
    run_fill(32'h0000_5678, 0, 1, outcome, edges, attempts);
    chk("midrst_refill", outcome, 1);

    // Randomized fills
    for (int t = 0; t < 40; t++) begin
      bit exp_err;
      int first_rty_fail;
      clear_plan();
      for (int a = 0; a <= MAX_RETRY; a++)
        if ($urandom_range(0, 3) == 0) rty_plan[a] = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) begin
        err_att = $urandom_range(0, 1); err_beat = $urandom_range(0, 7);
      end
      both_resp = 1'($urandom_range(0, 1));
      mid_miss  = 1'($urandom_range(0, 1));
      done_miss = 1'($urandom_range(0, 1));
      // Expected outcome from the plan: walk attempts until one ends clean,
      // hits an error, or retries run out.
      exp_err = 0; first_rty_fail = 0;
      for (int a = 0; a <= MAX_RETRY; a++) begin
        bit err_here;
        err_here = (err_att == a) && (rty_plan[a] < 0 || err_beat <= rty_plan[a]);
        if (err_here) begin exp_err = 1; break; end
        if (rty_plan[a] < 0) break;
        if (a == MAX_RETRY) exp_err = 1;
      end
      ra = $urandom;
      run_fill(ra, 0, 3, outcome, edges, attempts);
      chk("rand_outcome", outcome, exp_err ? 2 : 1);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
